// File: rtl/ntt_ctrl_pkg.sv
// Shared constants and state encoding for the NTT control sequencer.
// No logic here; latency and backpressure are defined by the users of this package.
package ntt_ctrl_pkg;

    localparam int LOGN_DEF = 3;
    localparam int NPTS_DEF = 8;

    localparam logic RW_READ  = 1'b0;
    localparam logic RW_WRITE = 1'b1;

    typedef enum logic [3:0] {
        ST_IDLE = 4'd0,
        ST_IDX  = 4'd1,
        ST_RD   = 4'd2,
        ST_CALC = 4'd3,
        ST_WAIT = 4'd4,
        ST_WR   = 4'd5,
        ST_NXT  = 4'd6,
        ST_DONE = 4'd7,
        ST_ERR  = 4'd8
    } state_e;

endpackage

// File: rtl/ntt_loop_counter.sv
// Nested stage/butterfly counter with registered span outputs; updates on the edge after inc/clr.
// No backpressure: inc is honoured every cycle it is asserted.
module ntt_loop_counter
    import ntt_ctrl_pkg::*;
#(
    parameter int n    = 4,
    parameter int LOGN = LOGN_DEF,
    parameter int NPTS = NPTS_DEF
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       clr,
    input  logic       inc,
    output logic [n:0] i,
    output logic [n:0] j,
    output logic [n:0] t,
    output logic [n:0] tprev,
    output logic       last_i,
    output logic       last_j
);

    localparam int         W      = n + 1;
    localparam logic [n:0] NPTS_W = W'(NPTS);
    localparam logic [n:0] J_MAX  = W'(NPTS / 2 - 1);
    localparam logic [n:0] I_MAX  = W'(LOGN - 1);

    logic [n:0] i_q, i_d;
    logic [n:0] j_q, j_d;
    logic [n:0] t_q, t_d;
    logic [n:0] tprev_q, tprev_d;

    always_comb begin
        i_d = i_q;
        j_d = j_q;
        if (clr) begin
            i_d = '0;
            j_d = '0;
        end else if (inc) begin
            if (j_q != J_MAX) begin
                j_d = j_q + 1'b1;
            end else begin
                j_d = '0;
                // the final stage holds i so spans stay valid until the next clr
                if (i_q != I_MAX) begin
                    i_d = i_q + 1'b1;
                end
            end
        end
        t_d     = NPTS_W >> (i_d + 1'b1);
        tprev_d = NPTS_W >> i_d;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            i_q     <= '0;
            j_q     <= '0;
            t_q     <= NPTS_W >> 1;
            tprev_q <= NPTS_W;
        end else begin
            i_q     <= i_d;
            j_q     <= j_d;
            t_q     <= t_d;
            tprev_q <= tprev_d;
        end
    end

    assign i      = i_q;
    assign j      = j_q;
    assign t      = t_q;
    assign tprev  = tprev_q;
    assign last_i = (i_q == I_MAX);
    assign last_j = (j_q == J_MAX);

endmodule

// File: rtl/ntt_sequencer.sv
// Control FSM for one in-place NTT; 6 cycles per butterfly with prompt acks, done 73 cycles after start.
// Stalls in WAIT until both tw_ack and buf_ack are seen; errors out (sticky) after TMO wait cycles.
module ntt_sequencer
    import ntt_ctrl_pkg::*;
#(
    parameter int n    = 4,
    parameter int LOGN = LOGN_DEF,
    parameter int NPTS = NPTS_DEF,
    parameter int TMO  = 64
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       start,
    output logic [n:0] i,
    output logic [n:0] j,
    output logic [n:0] N,
    output logic [n:0] t,
    output logic [n:0] tprev,
    output logic       start1,
    output logic       start2,
    output logic       enable,
    output logic       rw,
    input  logic       tw_ack,
    input  logic       buf_ack,
    output logic       busy,
    output logic       done,
    output logic       err
);

    localparam int              W      = n + 1;
    localparam int              CW     = $clog2(TMO + 1);
    localparam logic [n:0]      NPTS_W = W'(NPTS);
    localparam logic [CW-1:0]   TMO_W  = CW'(TMO);

    state_e        state_q, state_d;
    logic          tw_seen_q, tw_seen_d;
    logic          buf_seen_q, buf_seen_d;
    logic [CW-1:0] tmo_q, tmo_d;
    logic          start1_q, start1_d;
    logic          start2_q, start2_d;
    logic          enable_q, enable_d;
    logic          rw_q, rw_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          err_q, err_d;
    logic [n:0]    n_q;
    logic          cnt_clr, cnt_inc, last_i, last_j;

    ntt_loop_counter #(
        .n    (n),
        .LOGN (LOGN),
        .NPTS (NPTS)
    ) u_cnt (
        .clock  (clock),
        .reset  (reset),
        .clr    (cnt_clr),
        .inc    (cnt_inc),
        .i      (i),
        .j      (j),
        .t      (t),
        .tprev  (tprev),
        .last_i (last_i),
        .last_j (last_j)
    );

    always_comb begin
        state_d    = state_q;
        tw_seen_d  = tw_seen_q;
        buf_seen_d = buf_seen_q;
        tmo_d      = tmo_q;
        cnt_clr    = 1'b0;
        cnt_inc    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_IDX;
                    cnt_clr = 1'b1;
                end
            end
            ST_IDX:  state_d = ST_RD;
            ST_RD:   state_d = ST_CALC;
            ST_CALC: begin
                tw_seen_d  = 1'b0;
                buf_seen_d = 1'b0;
                tmo_d      = '0;
                state_d    = ST_WAIT;
            end
            ST_WAIT: begin
                tw_seen_d  = tw_seen_q | tw_ack;
                buf_seen_d = buf_seen_q | buf_ack;
                tmo_d      = tmo_q + 1'b1;
                // completing acks win over a timeout landing in the same cycle
                if (tw_seen_d && buf_seen_d) begin
                    state_d = ST_WR;
                end else if (tmo_d == TMO_W) begin
                    state_d = ST_ERR;
                end
            end
            ST_WR:   state_d = ST_NXT;
            ST_NXT: begin
                cnt_inc = 1'b1;
                state_d = (last_i && last_j) ? ST_DONE : ST_IDX;
            end
            ST_DONE: state_d = ST_IDLE;
            ST_ERR:  state_d = ST_ERR;
            default: state_d = ST_IDLE;
        endcase

        // outputs are registered off the next state so they align with it
        start1_d = (state_d == ST_IDX);
        start2_d = (state_d == ST_CALC);
        enable_d = (state_d == ST_RD) || (state_d == ST_WR);
        rw_d     = (state_d == ST_WR) ? RW_WRITE : RW_READ;
        done_d   = (state_d == ST_DONE);
        err_d    = (state_d == ST_ERR);
        busy_d   = (state_d != ST_IDLE) && (state_d != ST_DONE) && (state_d != ST_ERR);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            tw_seen_q  <= 1'b0;
            buf_seen_q <= 1'b0;
            tmo_q      <= '0;
            start1_q   <= 1'b0;
            start2_q   <= 1'b0;
            enable_q   <= 1'b0;
            rw_q       <= RW_READ;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            n_q        <= NPTS_W;
        end else begin
            state_q    <= state_d;
            tw_seen_q  <= tw_seen_d;
            buf_seen_q <= buf_seen_d;
            tmo_q      <= tmo_d;
            start1_q   <= start1_d;
            start2_q   <= start2_d;
            enable_q   <= enable_d;
            rw_q       <= rw_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
            n_q        <= NPTS_W;
        end
    end

    assign N      = n_q;
    assign start1 = start1_q;
    assign start2 = start2_q;
    assign enable = enable_q;
    assign rw     = rw_q;
    assign busy   = busy_q;
    assign done   = done_q;
    assign err    = err_q;

endmodule
